systolic_mac_row: RTL and testbench

//  Parametrised 1-D systolic MAC row: LANES MAC lanes fed by a stationary B vector that is skewed down the row one lane per step.

---
 rtl/systolic_mac_row.sv | 163 ++++++++++++++++
 tb/tb_systolic_mac_row.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_row.sv
// Systolic MAC row: LANES signed MAC lanes, stationary B skewed one lane per step.
// Define SYSTOLIC_MAC_SAT_EN for saturating accumulators with a sticky ovf flag.
module systolic_mac_row #(
    parameter int LANES  = 32,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int MAX_N  = 32,
    parameter int N_W    = $clog2(MAX_N + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_W-1:0]           n_len,
    input  logic [MAX_N*DATA_W-1:0]  b_vec,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [LANES*DATA_W-1:0]  a_vec,
    output logic                     busy,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic [LANES*ACC_W-1:0]   p_vec,
    output logic                     ovf
);

    localparam int T_W = $clog2(MAX_N + LANES);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0]   b_buf   [MAX_N];
    logic signed [DATA_W-1:0]   b_sr    [LANES-1];
    logic signed [ACC_W-1:0]    acc     [LANES];
    logic signed [ACC_W-1:0]    acc_nxt [LANES];
    logic signed [DATA_W-1:0]   ops     [LANES];
    logic signed [2*DATA_W-1:0] prod    [LANES];
    logic [N_W-1:0]             n_len_r;
    logic [N_W-1:0]             n_clamp;
    logic [T_W-1:0]             t;
    logic                       fire;
    logic                       last;
    logic                       sat_any;

`ifdef SYSTOLIC_MAC_SAT_EN
    logic signed [ACC_W:0]      sum     [LANES];
    logic                       ovf_r;
`endif

    assign fire    = (state == RUN) && a_valid;
    assign last    = t == (T_W'(n_len_r) + T_W'(LANES - 2));
    assign n_clamp = (n_len > N_W'(MAX_N)) ? N_W'(MAX_N) : n_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (n_len_r == '0) ? DONE : RUN;
            RUN:  if (fire && last) state_nxt = DONE;
            DONE: if (p_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_ready = (state == RUN);
        busy    = (state != IDLE);
        p_valid = (state == DONE);
        p_vec   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (state == DONE) p_vec[i*ACC_W +: ACC_W] = acc[i];
        end
    end

    // Lane 0 reads B directly; past n_len_r it feeds zeros so the tail drains.
    always_comb begin
        ops[0] = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (t == T_W'(k) && N_W'(k) < n_len_r) ops[0] = b_buf[k];
        end
        for (int i = 1; i < LANES; i++) begin
            ops[i] = b_sr[i-1];
        end
    end

    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = $signed(a_vec[i*DATA_W +: DATA_W]) * ops[i];
`ifdef SYSTOLIC_MAC_SAT_EN
            sum[i] = (ACC_W+1)'(acc[i]) + (ACC_W+1)'(prod[i]);
            if (sum[i][ACC_W] != sum[i][ACC_W-1]) begin
                sat_any    = 1'b1;
                acc_nxt[i] = sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_nxt[i] = sum[i][ACC_W-1:0];
            end
`else
            acc_nxt[i] = acc[i] + ACC_W'(prod[i]);
`endif
        end
    end

    // B and length are captured on the accepted start so LOAD sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_len_r <= '0;
            t       <= '0;
            for (int k = 0; k < MAX_N; k++) b_buf[k] <= '0;
            for (int i = 0; i < LANES-1; i++) b_sr[i] <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_len_r <= n_clamp;
                        for (int k = 0; k < MAX_N; k++) begin
                            b_buf[k] <= b_vec[k*DATA_W +: DATA_W];
                        end
                    end
                end
                LOAD: begin
                    t <= '0;
                    for (int i = 0; i < LANES-1; i++) b_sr[i] <= '0;
                    for (int i = 0; i < LANES; i++) acc[i] <= '0;
                end
                RUN: begin
                    if (fire) begin
                        t <= t + 1'b1;
                        for (int i = 0; i < LANES-1; i++) b_sr[i] <= ops[i];
                        for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYSTOLIC_MAC_SAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (state == LOAD) begin
            ovf_r <= 1'b0;
        end else if (fire && sat_any) begin
            ovf_r <= 1'b1;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_mac_row.sv
// Bench for systolic_mac_row: scoreboard of model results, checked on result handshake.
// LANES=4, DATA_W=16, ACC_W=32 so the wrap/saturation boundary is reachable.
module tb_systolic_mac_row;

    localparam int L  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int MN = 32;
    localparam int NW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [NW-1:0]   n_len = '0;
    logic [MN*DW-1:0] b_vec = '0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [L*DW-1:0] a_vec = '0;
    logic            busy;
    logic            p_valid;
    logic            p_ready = 1'b0;
    logic [L*AW-1:0] p_vec;
    logic            ovf;

    systolic_mac_row #(.LANES(L), .DATA_W(DW), .ACC_W(AW), .MAX_N(MN)) dut (
        .clk(clk), .reset(reset), .start(start), .n_len(n_len),
        .b_vec(b_vec), .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec),
        .busy(busy), .p_valid(p_valid), .p_ready(p_ready), .p_vec(p_vec),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*AW-1:0] p;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int bj[MN];
    int abeat[64][L];
    logic [AW-1:0] last_p0;
    logic last_ovf;
    bit seen_ready;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_data();
        for (int k = 0; k < MN; k++) bj[k] = 0;
        for (int t = 0; t < 64; t++)
            for (int i = 0; i < L; i++) abeat[t][i] = 0;
    endtask

    // Reference model: step-by-step accumulate in t order.
    task automatic model(input int n, output exp_t e);
        longint acc[L];
        longint mx, mn;
        logic signed [AW-1:0] w;
        int ne, s, bi, bv;
        mx = (64'sd1 <<< (AW-1)) - 1;
        mn = -(64'sd1 <<< (AW-1));
        ne = (n > MN) ? MN : n;
        s  = (ne == 0) ? 0 : ne + L - 1;
        e.ovf = 1'b0;
        for (int i = 0; i < L; i++) acc[i] = 0;
        for (int t = 0; t < s; t++) begin
            for (int i = 0; i < L; i++) begin
                bi = t - i;
                bv = (bi >= 0 && bi < ne) ? bj[bi] : 0;
                acc[i] = acc[i] + longint'(abeat[t][i] * bv);
`ifdef SYSTOLIC_MAC_SAT_EN
                if (acc[i] > mx) begin acc[i] = mx; e.ovf = 1'b1; end
                if (acc[i] < mn) begin acc[i] = mn; e.ovf = 1'b1; end
`else
                w = AW'(acc[i]);
                acc[i] = longint'(w);
`endif
            end
        end
        for (int i = 0; i < L; i++) e.p[i*AW +: AW] = AW'(acc[i]);
    endtask

    task automatic run_job(input int n, input int stall_pct,
                           input int hold, input bit start_in_done);
        exp_t e, g;
        logic [L*AW-1:0] first_p;
        int ne, s, cyc, hs;
        bit done;
        ne = (n > MN) ? MN : n;
        s  = (ne == 0) ? 0 : ne + L - 1;
        model(n, e);
        sb.push_back(e);
        @(negedge clk);
        n_len = NW'(n);
        for (int k = 0; k < MN; k++) b_vec[k*DW +: DW] = DW'(bj[k]);
        start = 1'b1;
        cyc = 0; hs = 0; done = 0; seen_ready = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (a_ready) seen_ready = 1;
            if (p_valid) begin
                a_valid = 1'b0;
                if (stall_pct == 0) chk("latency", cyc, 2 + s);
                chk("handshakes", hs, s);
                first_p = p_vec;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("hold_p", p_vec, first_p);
                    chk("hold_valid", p_valid, 1);
                end
                p_ready = 1'b1;
                start = start_in_done;
                g = sb.pop_front();
                for (int i = 0; i < L; i++)
                    chk($sformatf("p_lane%0d", i), p_vec[i*AW +: AW],
                        g.p[i*AW +: AW]);
                chk("ovf", ovf, g.ovf);
                last_p0 = p_vec[AW-1:0];
                last_ovf = ovf;
                @(negedge clk);
                p_ready = 1'b0;
                start = 1'b0;
                chk("busy_after", busy, 0);
                @(negedge clk);
                chk("idle_stays", busy, 0);
                done = 1;
            end else begin
                a_valid = (hs < s) && ($urandom_range(99) >= stall_pct);
                for (int i = 0; i < L; i++)
                    a_vec[i*DW +: DW] = DW'(abeat[hs][i]);
                if (a_valid && a_ready) hs++;
            end
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_aready", a_ready, 0);
        chk("rst_pvalid", p_valid, 0);
        chk("rst_pvec", p_vec, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // basic, no stalls
        clear_data();
        bj[0] = 3; bj[1] = 5;
        for (int t = 0; t < 5; t++)
            for (int i = 0; i < L; i++) abeat[t][i] = 1;
        run_job(2, 0, 2, 0);
        chk("t1_p0", last_p0, 8);

        // same with stalls
        run_job(2, 50, 0, 0);
        chk("t2_p0", last_p0, 8);

        // empty job
        clear_data();
        run_job(0, 0, 0, 0);
        chk("t3_noready", seen_ready, 0);

        // clamp to MAX_N
        for (int k = 0; k < MN; k++) bj[k] = $urandom_range(0, 200) - 100;
        for (int t = 0; t < 64; t++)
            for (int i = 0; i < L; i++)
                abeat[t][i] = $urandom_range(0, 2000) - 1000;
        run_job(40, 30, 0, 0);

        // signed
        clear_data();
        bj[0] = -3;
        abeat[0][0] = 2; abeat[0][1] = 2; abeat[0][2] = 2; abeat[0][3] = 2;
        abeat[1][0] = 9; abeat[1][1] = 7; abeat[1][2] = 7; abeat[1][3] = 7;
        run_job(1, 0, 0, 0);

        // accumulator boundary
        clear_data();
        for (int k = 0; k < 3; k++) bj[k] = 32'h7FFF;
        for (int t = 0; t < 64; t++) abeat[t][0] = 32'h7FFF;
        run_job(3, 0, 0, 0);
`ifdef SYSTOLIC_MAC_SAT_EN
        chk("t5_p0", last_p0, 32'h7FFFFFFF);
        chk("t5_ovf", last_ovf, 1);
`else
        chk("t5_p0", last_p0, 32'hBFFD0003);
        chk("t5_ovf", last_ovf, 0);
`endif

        // reset mid-RUN
        clear_data();
        bj[0] = 4; bj[1] = 4; bj[2] = 4;
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < L; i++) abeat[t][i] = t + i + 1;
        @(negedge clk);
        n_len = 3;
        for (int k = 0; k < MN; k++) b_vec[k*DW +: DW] = DW'(bj[k]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_valid = 1'b1;
        a_vec = {16'd9, 16'd9, 16'd9, 16'd9};
        repeat (3) @(negedge clk);
        chk("mid_ready", a_ready, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_aready", a_ready, 0);
        chk("abort_pvalid", p_valid, 0);
        chk("abort_pvec", p_vec, 0);
        chk("abort_ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b0;
        a_valid = 1'b0;
        run_job(3, 20, 2, 1);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
